// File: rtl/scs8hd_lpflow_pkg.sv
// rtl/scs8hd_lpflow_pkg.sv - shared state encoding and parameter limits for the lpflow power sequencer
package scs8hd_lpflow_pkg;

    localparam int PWRSEQ_NCH_MAX     = 16;
    localparam int PWRSEQ_STAGGER_MAX = 255;

    typedef enum logic [7:0] {
        ST_OFF     = 8'b0000_0001,
        ST_UP      = 8'b0000_0010,
        ST_SETTLE  = 8'b0000_0100,
        ST_RESTORE = 8'b0000_1000,
        ST_ON      = 8'b0001_0000,
        ST_ISO     = 8'b0010_0000,
        ST_SAVE    = 8'b0100_0000,
        ST_DOWN    = 8'b1000_0000
    } pwrseq_state_e;

endpackage

// File: rtl/scs8hd_lpflow_pwrseq_tmr.sv
// rtl/scs8hd_lpflow_pwrseq_tmr.sv - loadable down-counter timing the channel stagger and settle
module scs8hd_lpflow_pwrseq_tmr #(
    parameter int W        = 4,
    parameter int LOAD_VAL = 7
) (
    input  logic clk,
    input  logic reset,
    input  logic load,
    output logic done
);

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    // Reload on request, otherwise count down and park at zero.
    always_comb begin
        cnt_d = cnt_q;
        if (load) begin
            cnt_d = W'(LOAD_VAL);
        end else if (cnt_q != '0) begin
            cnt_d = cnt_q - 1'b1;
        end
    end

    // Counter register.
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign done = (cnt_q == '0);

endmodule

// File: rtl/scs8hd_lpflow_pwrseq_ctrl.sv
// rtl/scs8hd_lpflow_pwrseq_ctrl.sv - staged header-switch sequencer; SCS8HD_LPFLOW_RET_EN adds retention save/restore
module scs8hd_lpflow_pwrseq_ctrl
    import scs8hd_lpflow_pkg::*;
#(
    parameter int NCH     = 4,
    parameter int STAGGER = 8
) (
    input  logic           clk,
    input  logic           reset,
    input  logic           pwr_req,
    output logic           pwr_ack,
    output logic [NCH-1:0] sw_en,
    output logic           iso_en,
    output logic           save,
    output logic           restore
);

    localparam int TW = $clog2(STAGGER + 1);
    localparam int CW = (NCH > 1) ? $clog2(NCH) : 1;
    // Index of the second-highest channel: last UP step before SETTLE, first DOWN index.
    localparam logic [CW-1:0] IDX_PENULT = CW'(NCH - 2);

    if (NCH < 1 || NCH > PWRSEQ_NCH_MAX) begin : g_bad_nch
        $error("scs8hd_lpflow_pwrseq_ctrl: NCH out of range 1..16");
    end
    if (STAGGER < 1 || STAGGER > PWRSEQ_STAGGER_MAX) begin : g_bad_stagger
        $error("scs8hd_lpflow_pwrseq_ctrl: STAGGER out of range 1..255");
    end

    pwrseq_state_e  state_q, state_d;
    logic [NCH-1:0] sw_en_q, sw_en_d;
    logic [CW-1:0]  idx_q, idx_d;
    logic           iso_en_q, iso_en_d;
    logic           pwr_ack_q, pwr_ack_d;
    logic           save_q, save_d;
    logic           restore_q, restore_d;
    logic           tmr_load;
    logic           tmr_done;
    logic           go_on;
    logic           go_down;

    scs8hd_lpflow_pwrseq_tmr #(
        .W        (TW),
        .LOAD_VAL (STAGGER - 1)
    ) u_tmr (
        .clk   (clk),
        .reset (reset),
        .load  (tmr_load),
        .done  (tmr_done)
    );

    // Next state and next registered outputs; isolation stays clamped unless fully on.
    always_comb begin
        state_d   = state_q;
        sw_en_d   = sw_en_q;
        idx_d     = idx_q;
        iso_en_d  = 1'b1;
        pwr_ack_d = 1'b0;
        save_d    = 1'b0;
        restore_d = 1'b0;
        tmr_load  = 1'b0;
        go_on     = 1'b0;
        go_down   = 1'b0;
        case (state_q)
            ST_OFF: begin
                if (pwr_req) begin
                    sw_en_d  = NCH'(1);
                    idx_d    = '0;
                    tmr_load = 1'b1;
                    if (NCH == 1) begin
                        state_d = ST_SETTLE;
                    end else begin
                        state_d = ST_UP;
                    end
                end
            end
            ST_UP: begin
                if (tmr_done) begin
                    sw_en_d  = (sw_en_q << 1) | NCH'(1);
                    idx_d    = idx_q + 1'b1;
                    tmr_load = 1'b1;
                    if (idx_q == IDX_PENULT) begin
                        state_d = ST_SETTLE;
                    end
                end
            end
            ST_SETTLE: begin
                if (tmr_done) begin
`ifdef SCS8HD_LPFLOW_RET_EN
                    state_d   = ST_RESTORE;
                    restore_d = 1'b1;
`else
                    go_on = 1'b1;
`endif
                end
            end
`ifdef SCS8HD_LPFLOW_RET_EN
            ST_RESTORE: begin
                go_on = 1'b1;
            end
`endif
            ST_ON: begin
                if (pwr_req) begin
                    pwr_ack_d = 1'b1;
                    iso_en_d  = 1'b0;
                end else begin
                    state_d = ST_ISO;
                end
            end
            ST_ISO: begin
`ifdef SCS8HD_LPFLOW_RET_EN
                state_d = ST_SAVE;
                save_d  = 1'b1;
`else
                go_down = 1'b1;
`endif
            end
`ifdef SCS8HD_LPFLOW_RET_EN
            ST_SAVE: begin
                go_down = 1'b1;
            end
`endif
            ST_DOWN: begin
                if (tmr_done) begin
                    sw_en_d = sw_en_q >> 1;
                    if (idx_q == '0) begin
                        state_d = ST_OFF;
                    end else begin
                        idx_d    = idx_q - 1'b1;
                        tmr_load = 1'b1;
                    end
                end
            end
            default: begin
                state_d = ST_OFF;
                sw_en_d = '0;
                idx_d   = '0;
            end
        endcase

        if (go_on) begin
            state_d   = ST_ON;
            pwr_ack_d = 1'b1;
            iso_en_d  = 1'b0;
        end

        // Top channel drops on DOWN entry; a single channel means the domain is already off.
        if (go_down) begin
            sw_en_d  = sw_en_q >> 1;
            tmr_load = 1'b1;
            if (NCH == 1) begin
                state_d = ST_OFF;
            end else begin
                state_d = ST_DOWN;
                idx_d   = IDX_PENULT;
            end
        end
    end

    // State and output registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= ST_OFF;
            sw_en_q   <= '0;
            idx_q     <= '0;
            iso_en_q  <= 1'b1;
            pwr_ack_q <= 1'b0;
            save_q    <= 1'b0;
            restore_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            sw_en_q   <= sw_en_d;
            idx_q     <= idx_d;
            iso_en_q  <= iso_en_d;
            pwr_ack_q <= pwr_ack_d;
            save_q    <= save_d;
            restore_q <= restore_d;
        end
    end

    assign sw_en   = sw_en_q;
    assign iso_en  = iso_en_q;
    assign pwr_ack = pwr_ack_q;
    assign save    = save_q;
    assign restore = restore_q;

endmodule

// File: doc/scs8hd_lpflow_pwrseq_ctrl.md
# scs8hd_lpflow_pwrseq_ctrl

Parametrised power-switch sequencer for a switchable domain sitting beside an always-on keep-alive (kapwr) rail. It stages N header-switch channels on and off at a fixed stagger to bound inrush and decap droop. Around each transition it drives isolation and, optionally, retention save/restore strobes. It runs on the always-on domain and hands a level `pwr_ack` back to the low-power controller.

## Interface
Parameters:
- `NCH`, 4: number of switch channels, legal range 1..16.
- `STAGGER`, 8: cycles between successive channel transitions, and the settle time after the last channel turns on; legal range 1..255.

Ports:
- `clk`  in  1  sole clock, always-on domain.
- `reset`  in  1  synchronous, active-high reset.
- `pwr_req`  in  1  level request: 1 = domain on, 0 = domain off.
- `pwr_ack`  out  1  1 only while the domain is fully on (state ON).
- `sw_en`  out  NCH  per-channel header-switch enable, 1 = conducting.
- `iso_en`  out  1  isolation clamp enable, 1 = outputs clamped.
- `save`  out  1  one-cycle retention save strobe.
- `restore`  out  1  one-cycle retention restore strobe.

All outputs are registered. The block has one clock. Reset is synchronous and active-high.

## Operation
- States: OFF, UP, SETTLE, RESTORE, ON, ISO, SAVE, DOWN. The FSM encoding is a one-hot enum.
- Reset values: state = OFF, `sw_en` = 0, `iso_en` = 1, `save` = 0, `restore` = 0, `pwr_ack` = 0. Reset asserted mid-sequence forces these values on the next edge, regardless of state.
- OFF to UP: taken when `pwr_req` = 1. On entering UP, `sw_en[0]` rises.
- In UP: `sw_en[i]` rises STAGGER cycles after `sw_en[i-1]`, in ascending order.
- UP to SETTLE: taken once `sw_en[NCH-1]` is set. SETTLE lasts STAGGER cycles, then the FSM goes to RESTORE.
- RESTORE: `restore` = 1 for exactly one cycle, then the FSM goes to ON.
- Entering ON: `iso_en` falls and `pwr_ack` rises on the same edge.
- ON to ISO: taken when `pwr_req` = 0. On this edge `pwr_ack` falls and `iso_en` rises.
- ISO to SAVE: ISO lasts one cycle. SAVE drives `save` = 1 for one cycle.
- DOWN: `sw_en[NCH-1]` falls on entry. Then one channel falls every STAGGER cycles, in descending order. The edge that clears `sw_en[0]` also enters OFF.
- No abort: `pwr_req` is ignored in UP, SETTLE, RESTORE, ISO, SAVE and DOWN. It is re-sampled only in ON and OFF. A request toggled during a sequence takes effect after that sequence completes.
- Invariants: `iso_en` = 1 whenever any `sw_en` bit is 0. `sw_en` is always thermometer-coded (bits 0..k set). `save` and `restore` are never both high.
- Widths: stagger counter is $clog2(STAGGER+1) bits and loads STAGGER-1. Channel index is $clog2(NCH) bits, with a minimum of 1 bit. When NCH = 1, UP goes directly to SETTLE. When STAGGER = 1, channels transition on consecutive cycles.

## Timing
- Power-up: `pwr_req` = 1 is sampled in OFF at edge k.
  - `sw_en[i]` rises at k+1+i·STAGGER.
  - `restore` is high at k+1+NCH·STAGGER.
  - ON (`pwr_ack` = 1) is reached at k+2+NCH·STAGGER. For defaults this is k+34.
- Power-down: `pwr_req` = 0 is sampled in ON at edge k.
  - `iso_en` = 1 and `pwr_ack` = 0 at k+1.
  - `save` is high at k+2.
  - `sw_en[NCH-1-j]` falls at k+3+j·STAGGER.
  - OFF is reached at k+3+(NCH-1)·STAGGER. For defaults this is k+27.

## Configuration
- `SCS8HD_LPFLOW_RET_EN`
  - Defined: RESTORE and SAVE states exist and strobe as specified above.
  - Undefined: RESTORE and SAVE are removed. SETTLE goes directly to ON, and ISO goes directly to DOWN. `save` and `restore` are tied to 0. Every up/down timing figure above shrinks by 1 cycle: ON at k+1+NCH·STAGGER, DOWN entry at k+2.

## Structure
- Shared package `scs8hd_lpflow_pkg` holds:
  - the state enum `pwrseq_state_e`;
  - the parameter-legality limits `PWRSEQ_NCH_MAX` = 16 and `PWRSEQ_STAGGER_MAX` = 255.
- One sub-module, `scs8hd_lpflow_pwrseq_tmr`: loadable down-counter with a `load` input and a `done` output, shared by UP, SETTLE and DOWN.
- Elaboration-time assertions reject parameters outside the legal ranges.

## Test plan
- Reset, then `pwr_req` = 1 at cycle 0 with defaults and RET_EN defined:
  - `sw_en` reads 0001, 0011, 0111, 1111 at cycles 1, 9, 17, 25;
  - `restore` pulses at cycle 33;
  - `pwr_ack` and `iso_en` = 0 at cycle 34.
- From ON, `pwr_req` = 0 at cycle 0:
  - `iso_en` = 1 at cycle 1;
  - `save` pulses at cycle 2;
  - `sw_en` reads 0111, 0011, 0001, 0000 at cycles 3, 11, 19, 27.
- Toggle `pwr_req` 1, then 0, at cycle 5 of power-up: the sequence completes to ON, then power-down starts one cycle after ON.
- Assert `reset` while `sw_en` = 0011 mid-UP: on the next edge all outputs return to their reset values and the state is OFF.
- NCH = 1, STAGGER = 1, RET_EN undefined, `pwr_req` = 1 at cycle 0: `sw_en` = 1 at cycle 1 and `pwr_ack` = 1 at cycle 2.
- Random `pwr_req` over 10k cycles with NCH = 5, STAGGER = 3:
  - the invariants hold throughout: `sw_en` thermometer-coded, `iso_en` = 1 when any `sw_en` bit is 0, no `save`/`restore` overlap;
  - `pwr_ack` is high only while `sw_en` is all ones.
